scope_trace: RTL and testbench

- Waveform capture and render stage that sits directly upstream of the vga block.
- Captures a stream of 8-bit samples into a DEPTH-entry buffer once a level trigger fires.
- Draws the captured waveform, plus a trigger-level marker, as a 6-bit color_px stream.
- color_px is ORed into the vga color_px bus alongside the numbers and color_sq outputs. Runs entirely in the vga_clk domain.

---
 rtl/scope_trace_pkg.sv | 20 ++
 rtl/scope_trace_if.sv | 26 ++
 rtl/scope_trace_ram.sv | 22 ++
 rtl/scope_trace.sv | 161 ++++++++++++++++
 tb/tb_scope_trace.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/scope_trace_pkg.sv
// Shared colors, FSM encoding and window geometry for the scope trace block.
// Latency and backpressure: n/a (declarations only).
package scope_trace_pkg;

  typedef enum logic [1:0] {
    ARMED   = 2'd0,
    CAPTURE = 2'd1,
    HOLD    = 2'd2
  } state_t;

  localparam logic [5:0] BLACK  = 6'b000000;
  localparam logic [5:0] BLUE   = 6'b000011;
  localparam logic [5:0] GREEN  = 6'b001100;
  localparam logic [5:0] RED    = 6'b110000;
  localparam logic [5:0] YELLOW = 6'b111100;
  localparam logic [5:0] WHITE  = 6'b111111;

  localparam int WIN_ROWS = 256;

endpackage

// File: rtl/scope_trace_if.sv
// Sample stream, trigger controls and vga pixel bus of the scope trace block.
// Latency: none (wiring only); backpressure: none, all signals are plain strobes/levels.
interface scope_trace_if;

  logic [7:0]  sample;
  logic        sample_en;
  logic [7:0]  level;
  logic        trig_rising;
  logic        force_mode;
  logic [10:0] x_px;
  logic [9:0]  y_px;
  logic [5:0]  color_px;
  logic        armed;
  logic        triggered;

  modport master (
    output sample, sample_en, level, trig_rising, force_mode, x_px, y_px,
    input  color_px, armed, triggered
  );

  modport slave (
    input  sample, sample_en, level, trig_rising, force_mode, x_px, y_px,
    output color_px, armed, triggered
  );

endinterface

// File: rtl/scope_trace_ram.sv
// DEPTH x 8 simple dual-port RAM, one write port and one registered read port.
// Latency: rdat follows raddr by 1 cycle; backpressure: none, read-during-write returns old data.
module trace_ram #(
  parameter int DEPTH = 512,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdat,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdat
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdat;
    rdat <= mem[raddr];
  end

endmodule

// File: rtl/scope_trace.sv
// Level-triggered sample capture and waveform/trigger-level renderer for the vga color bus.
// Latency: color_px 2 cycles after x_px/y_px; backpressure: none, strobes are dropped outside ARMED/CAPTURE.
module scope_trace
  import scope_trace_pkg::*;
#(
  parameter int         DEPTH     = 512,
  parameter int         X_OFF     = 64,
  parameter int         Y_OFF     = 112,
  parameter logic [5:0] INK       = YELLOW,
  parameter logic [5:0] LEVEL_INK = BLUE,
  parameter int         HOLDOFF   = 8
) (
  input logic          clk,
  input logic          reset_n,
  scope_trace_if.slave bus
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [10:0] X_LO      = 11'(X_OFF);
  localparam logic [10:0] X_HI      = 11'(X_OFF + DEPTH);
  localparam logic [9:0]  Y_LO      = 10'(Y_OFF);
  localparam logic [9:0]  Y_HI      = 10'(Y_OFF + WIN_ROWS);
  localparam logic [15:0] HOLD_LAST = 16'(HOLDOFF - 1);

  state_t        state, state_nxt;
  logic [AW-1:0] wr_ptr, wr_ptr_nxt;
  logic [7:0]    prev, prev_nxt;
  logic          prev_valid, prev_valid_nxt;
  logic          valid, valid_nxt;
  logic [15:0]   holdoff_cnt, holdoff_cnt_nxt;
  logic          trig, triggered_q;
  logic          at_origin, at_origin_d, frame_start;
  logic          we;
  logic [AW-1:0] waddr;

  // A frame start is the first cycle at the origin, so a parked pixel counts once.
  assign at_origin   = (bus.x_px == 11'd0) && (bus.y_px == 10'd0);
  assign frame_start = at_origin && !at_origin_d;

  always_comb begin
    trig = 1'b0;
    if ((state == ARMED) && bus.sample_en) begin
      if (bus.force_mode)
        trig = 1'b1;
      else if (prev_valid)
        trig = bus.trig_rising ? ((prev <  bus.level) && (bus.sample >= bus.level))
                               : ((prev >= bus.level) && (bus.sample <  bus.level));
    end
  end

  always_comb begin
    state_nxt       = state;
    wr_ptr_nxt      = wr_ptr;
    prev_nxt        = prev;
    prev_valid_nxt  = prev_valid;
    valid_nxt       = valid;
    holdoff_cnt_nxt = holdoff_cnt;
    we              = 1'b0;
    waddr           = wr_ptr;
    unique case (state)
      ARMED: begin
        if (bus.sample_en) begin
          prev_nxt       = bus.sample;
          prev_valid_nxt = 1'b1;
          if (trig) begin
            we         = 1'b1;
            waddr      = '0;
            wr_ptr_nxt = AW'(1);
            state_nxt  = CAPTURE;
          end
        end
      end
      CAPTURE: begin
        if (bus.sample_en) begin
          we         = 1'b1;
          wr_ptr_nxt = wr_ptr + AW'(1);
          if (wr_ptr == AW'(DEPTH - 1)) begin
            valid_nxt      = 1'b1;
            prev_valid_nxt = 1'b0;
            state_nxt      = HOLD;
          end
        end
      end
      HOLD: begin
        if (frame_start) begin
          if ((HOLDOFF == 0) || (holdoff_cnt == HOLD_LAST)) begin
            holdoff_cnt_nxt = '0;
            state_nxt       = ARMED;
          end else begin
            holdoff_cnt_nxt = holdoff_cnt + 16'd1;
          end
        end
      end
      default: state_nxt = ARMED;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ARMED;
      wr_ptr      <= '0;
      prev        <= '0;
      prev_valid  <= 1'b0;
      valid       <= 1'b0;
      holdoff_cnt <= '0;
      triggered_q <= 1'b0;
      at_origin_d <= 1'b0;
    end else begin
      state       <= state_nxt;
      wr_ptr      <= wr_ptr_nxt;
      prev        <= prev_nxt;
      prev_valid  <= prev_valid_nxt;
      valid       <= valid_nxt;
      holdoff_cnt <= holdoff_cnt_nxt;
      triggered_q <= trig;
      at_origin_d <= at_origin;
    end
  end

  assign bus.armed     = (state == ARMED);
  assign bus.triggered = triggered_q;

  logic          in_win, in_win_d1;
  logic [9:0]    y_d1;
  logic [AW-1:0] raddr;
  logic [7:0]    rd_dat, row;
  logic          hit_trace, hit_level;

  assign in_win = (bus.x_px >= X_LO) && (bus.x_px < X_HI) &&
                  (bus.y_px >= Y_LO) && (bus.y_px < Y_HI);
  assign raddr  = AW'(bus.x_px - X_LO);

  trace_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdat  (bus.sample),
    .raddr (raddr),
    .rdat  (rd_dat)
  );

  // Row 0 is the top of the window, so a value v draws on row 255-v (= ~v).
  assign row = 8'(y_d1 - Y_LO);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_win_d1 <= 1'b0;
      y_d1      <= '0;
      hit_trace <= 1'b0;
      hit_level <= 1'b0;
    end else begin
      in_win_d1 <= in_win;
      y_d1      <= bus.y_px;
      hit_trace <= valid && in_win_d1 && (row == ~rd_dat);
      hit_level <= in_win_d1 && (row == ~bus.level);
    end
  end

  assign bus.color_px = hit_trace ? INK : (hit_level ? LEVEL_INK : 6'b000000);

endmodule

// File: tb/tb_scope_trace.sv
// Scoreboard bench for scope_trace: a HOLDOFF=2 and a HOLDOFF=0 instance see the same stimulus.
// Expected triggered/color_px values are queued at drive time and popped when the DUT output is due.
module tb_scope_trace;
  import scope_trace_pkg::*;

  localparam int DEPTH = 512;
  localparam int X_OFF = 64;
  localparam int Y_OFF = 112;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   passes = 0;

  scope_trace_if bus ();
  scope_trace_if bus0 ();

  scope_trace #(.DEPTH(DEPTH), .X_OFF(X_OFF), .Y_OFF(Y_OFF), .INK(YELLOW),
                .LEVEL_INK(BLUE), .HOLDOFF(2)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.slave));

  scope_trace #(.DEPTH(DEPTH), .X_OFF(X_OFF), .Y_OFF(Y_OFF), .INK(YELLOW),
                .LEVEL_INK(BLUE), .HOLDOFF(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0.slave));

  assign bus0.sample      = bus.sample;
  assign bus0.sample_en   = bus.sample_en;
  assign bus0.level       = bus.level;
  assign bus0.trig_rising = bus.trig_rising;
  assign bus0.force_mode  = bus.force_mode;
  assign bus0.x_px        = bus.x_px;
  assign bus0.y_px        = bus.y_px;

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_px(input int x, input int y);
    bus.x_px = 11'(x);
    bus.y_px = 10'(y);
  endtask

  task automatic send(input logic [7:0] s);
    bus.sample    = s;
    bus.sample_en = 1'b1;
    tick();
    bus.sample_en = 1'b0;
  endtask

  task automatic test_reset();
    bus.sample = 8'd0; bus.sample_en = 1'b0; bus.level = 8'd128;
    bus.trig_rising = 1'b1; bus.force_mode = 1'b0;
    drive_px(1000, 1000);
    reset_n = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    tick(); tick();
    checks++; if (bus.armed !== 1'b1) $display("FAIL reset_armed: got %b want 1", bus.armed); else passes++;
    checks++; if (bus0.armed !== 1'b1) $display("FAIL reset_armed0: got %b want 1", bus0.armed); else passes++;
    checks++; if (bus.triggered !== 1'b0) $display("FAIL reset_triggered: got %b want 0", bus.triggered); else passes++;
    checks++; if (bus.color_px !== 6'd0) $display("FAIL reset_color: got %b want 000000", bus.color_px); else passes++;
  endtask

  task automatic test_idle_render();
    int         xs[8] = '{64, 575, 300, 63, 576, 300, 300, 300};
    int         ys[8] = '{239, 239, 239, 239, 239, 238, 240, 495};
    logic [5:0] es[8] = '{BLUE, BLUE, BLUE, BLACK, BLACK, BLACK, BLACK, BLACK};
    logic [5:0] q[$];
    logic [5:0] e;
    bus.level = 8'd128;
    for (int i = 0; i < 8; i++) begin
      drive_px(xs[i], ys[i]); q.push_back(es[i]); tick();
      if (q.size() > 1) begin
        e = q.pop_front();
        checks++; if (bus.color_px !== e) $display("FAIL idle_render[%0d]: got %b want %b", i - 1, bus.color_px, e); else passes++;
      end
    end
    drive_px(1000, 1000); tick();
    e = q.pop_front();
    checks++; if (bus.color_px !== e) $display("FAIL idle_render[7]: got %b want %b", bus.color_px, e); else passes++;
  endtask

  task automatic test_rising_capture();
    int   samp[4] = '{50, 99, 100, 101};
    logic q[$];
    logic e;
    bus.level = 8'd100; bus.trig_rising = 1'b1; bus.force_mode = 1'b0;
    for (int i = 0; i < 4; i++) begin
      q.push_back(i == 2); send(8'(samp[i]));
      e = q.pop_front();
      checks++; if (bus.triggered !== e) $display("FAIL rising_trig[%0d]: got %b want %b", i, bus.triggered, e); else passes++;
    end
    checks++; if (bus.armed !== 1'b0) $display("FAIL rising_capture_armed: got %b want 0", bus.armed); else passes++;
    for (int i = 2; i < DEPTH - 1; i++) begin
      q.push_back(1'b0); send(8'(i));
      e = q.pop_front();
      checks++; if (bus.triggered !== e) $display("FAIL capture_trig[%0d]: got %b want %b", i, bus.triggered, e); else passes++;
    end
    // The completing write lands on a frame start, which must not count toward holdoff.
    drive_px(0, 0);
    send(8'd255);
    drive_px(1000, 1000);
    tick(); tick(); tick();
    checks++; if (bus.armed !== 1'b0) $display("FAIL hold_after_capture: got %b want 0", bus.armed); else passes++;
    checks++; if (bus0.armed !== 1'b0) $display("FAIL hold0_complete_not_frame: got %b want 0", bus0.armed); else passes++;
  endtask

  task automatic test_render_trace();
    int         xs[14] = '{74, 74, 64, 65, 364, 575, 320, 192, 193, 193, 63, 576, 320, 575};
    int         ys[14] = '{357, 356, 267, 266, 323, 112, 367, 239, 239, 238, 112, 267, 111, 368};
    logic [5:0] es[14] = '{YELLOW, BLACK, YELLOW, YELLOW, YELLOW, YELLOW, YELLOW, YELLOW,
                           BLUE, YELLOW, BLACK, BLACK, BLACK, BLACK};
    logic [5:0] q[$];
    logic [5:0] e;
    bus.level = 8'd128;
    for (int i = 0; i < 14; i++) begin
      drive_px(xs[i], ys[i]); q.push_back(es[i]); tick();
      if (q.size() > 1) begin
        e = q.pop_front();
        checks++; if (bus.color_px !== e) $display("FAIL trace_render[%0d]: got %b want %b", i - 1, bus.color_px, e); else passes++;
      end
    end
    drive_px(1000, 1000); tick();
    e = q.pop_front();
    checks++; if (bus.color_px !== e) $display("FAIL trace_render[13]: got %b want %b", bus.color_px, e); else passes++;
  endtask

  task automatic test_hold_ignores_sample();
    int         xs[3] = '{64, 64, 74};
    int         ys[3] = '{267, 367, 357};
    logic [5:0] es[3] = '{YELLOW, BLACK, YELLOW};
    logic [5:0] q[$];
    logic [5:0] e;
    bus.force_mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(8'd0);
      checks++; if (bus.triggered !== 1'b0) $display("FAIL hold_trig[%0d]: got %b want 0", i, bus.triggered); else passes++;
    end
    bus.force_mode = 1'b0;
    checks++; if (bus.armed !== 1'b0) $display("FAIL hold_armed: got %b want 0", bus.armed); else passes++;
    for (int i = 0; i < 3; i++) begin
      drive_px(xs[i], ys[i]); q.push_back(es[i]); tick();
      if (q.size() > 1) begin
        e = q.pop_front();
        checks++; if (bus.color_px !== e) $display("FAIL hold_render[%0d]: got %b want %b", i - 1, bus.color_px, e); else passes++;
      end
    end
    drive_px(1000, 1000); tick();
    e = q.pop_front();
    checks++; if (bus.color_px !== e) $display("FAIL hold_render[2]: got %b want %b", bus.color_px, e); else passes++;
  endtask

  task automatic test_holdoff();
    // Parking on the origin for several cycles is still one frame start.
    drive_px(0, 0); tick(); tick(); tick();
    drive_px(1000, 1000); tick();
    checks++; if (bus.armed !== 1'b0) $display("FAIL holdoff2_fs1: got %b want 0", bus.armed); else passes++;
    checks++; if (bus0.armed !== 1'b1) $display("FAIL holdoff0_fs1: got %b want 1", bus0.armed); else passes++;
    drive_px(0, 0); tick();
    drive_px(1000, 1000); tick();
    checks++; if (bus.armed !== 1'b1) $display("FAIL holdoff2_fs2: got %b want 1", bus.armed); else passes++;
    checks++; if (bus0.armed !== 1'b1) $display("FAIL holdoff0_fs2: got %b want 1", bus0.armed); else passes++;
  endtask

  task automatic test_falling();
    int   samp[5] = '{50, 150, 120, 110, 99};
    logic q[$];
    logic e;
    bus.level = 8'd100; bus.trig_rising = 1'b0; bus.force_mode = 1'b0;
    for (int i = 0; i < 5; i++) begin
      q.push_back(i == 4); send(8'(samp[i]));
      e = q.pop_front();
      checks++; if (bus.triggered !== e) $display("FAIL falling_trig[%0d]: got %b want %b", i, bus.triggered, e); else passes++;
    end
    checks++; if (bus.armed !== 1'b0) $display("FAIL falling_armed: got %b want 0", bus.armed); else passes++;
  endtask

  task automatic test_reset_mid_capture();
    int         xs[3] = '{74, 300, 64};
    int         ys[3] = '{357, 267, 268};
    logic [5:0] es[3] = '{BLACK, BLUE, BLACK};
    logic [5:0] q[$];
    logic [5:0] e;
    drive_px(300, 267);
    for (int i = 1; i < 200; i++) send(8'(i));
    checks++; if (bus.color_px !== BLUE) $display("FAIL midcap_level_line: got %b want %b", bus.color_px, BLUE); else passes++;
    reset_n = 1'b0;
    #2;
    checks++; if (bus.armed !== 1'b1) $display("FAIL midcap_reset_armed: got %b want 1", bus.armed); else passes++;
    checks++; if (bus.color_px !== 6'd0) $display("FAIL midcap_reset_color: got %b want 000000", bus.color_px); else passes++;
    checks++; if (bus.triggered !== 1'b0) $display("FAIL midcap_reset_trig: got %b want 0", bus.triggered); else passes++;
    tick();
    reset_n = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      drive_px(xs[i], ys[i]); q.push_back(es[i]); tick();
      if (q.size() > 1) begin
        e = q.pop_front();
        checks++; if (bus.color_px !== e) $display("FAIL midcap_render[%0d]: got %b want %b", i - 1, bus.color_px, e); else passes++;
      end
    end
    drive_px(1000, 1000); tick();
    e = q.pop_front();
    checks++; if (bus.color_px !== e) $display("FAIL midcap_render[2]: got %b want %b", bus.color_px, e); else passes++;
  endtask

  task automatic test_force();
    bus.level = 8'd100; bus.trig_rising = 1'b1; bus.force_mode = 1'b1;
    send(8'd50);
    checks++; if (bus.triggered !== 1'b1) $display("FAIL force_trig: got %b want 1", bus.triggered); else passes++;
    bus.force_mode = 1'b0;
    send(8'd50);
    checks++; if (bus.triggered !== 1'b0) $display("FAIL force_second: got %b want 0", bus.triggered); else passes++;
    checks++; if (bus.armed !== 1'b0) $display("FAIL force_armed: got %b want 0", bus.armed); else passes++;
  endtask

  initial begin
    test_reset();
    test_idle_render();
    test_rising_capture();
    test_render_trace();
    test_hold_ignores_sample();
    test_holdoff();
    test_falling();
    test_reset_mid_capture();
    test_force();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
